risc_pipe_ctrl: RTL and testbench

Pipeline sequencing and hazard controller for the 3-stage RISC core (IF -> ID -> EX/WB, 32x32 register file, byte-addressed instruction memory with PC step 4). It decides each cycle whether PC and IF_ID advance, whether ID_EX takes a bubble, and which operand source ID uses. It also runs a start/drain/idle state machine and keeps stall and retire statistics. The datapath instantiates it in place of ad-hoc stall/forward wires.

---
 rtl/risc_pkg.sv | 30 +++
 rtl/risc_hazard_cmp.sv | 50 +++++
 rtl/risc_pipe_ctrl.sv | 174 +++++++++++++++++
 tb/tb_risc_pipe_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : risc_pkg
// Description : Shared types and constants for the 3-stage RISC pipeline
//               controller: controller state encoding, operand-source select
//               encoding and the default register index width.
// Revision    : 1.0 - initial release
// ============================================================================
package risc_pkg;

    // Default register index width (32-entry register file)
    localparam int REG_AW = 5;

    // Controller state, visible on the state output
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        STALL = 2'b10,
        DRAIN = 2'b11
    } state_e;

    // Operand source select for the ID stage
    typedef enum logic [1:0] {
        REGFILE = 2'b00,
        ALU     = 2'b01,
        WB      = 2'b10
    } fwd_sel_e;

endpackage
`default_nettype wire

// File: rtl/risc_hazard_cmp.sv
`default_nettype none
// ============================================================================
// Module      : risc_hazard_cmp
// Description : Combinational dependency check for one ID source operand.
//               Compares the operand index against the EX and WB destinations
//               and reports where the freshest value lives. A non-REGFILE
//               result means the operand depends on an in-flight instruction.
// Ports       : id_rs              - ID source register index
//               ex_valid / ex_rd   - ID_EX occupancy and destination
//               wb_valid / wb_rd   - EX_WB occupancy and destination
//               fwd_sel            - 00 regfile, 01 ALU (EX), 10 WB data
// Revision    : 1.0 - initial release
// ============================================================================
module risc_hazard_cmp #(
    parameter int REG_AW     = 5,
    parameter int R0_IS_ZERO = 0
) (
    input  logic [REG_AW-1:0] id_rs,
    input  logic              ex_valid,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_rd,
    output logic [1:0]        fwd_sel
);
    import risc_pkg::*;

    logic w_ex_live;
    logic w_wb_live;
    logic w_ex_hit;
    logic w_wb_hit;

    // A write to r0 is discarded when r0 is hard-wired, so it is not a producer
    assign w_ex_live = ex_valid && !((R0_IS_ZERO != 0) && (ex_rd == '0));
    assign w_wb_live = wb_valid && !((R0_IS_ZERO != 0) && (wb_rd == '0));

    assign w_ex_hit = w_ex_live && (ex_rd == id_rs);
    assign w_wb_hit = w_wb_live && (wb_rd == id_rs);

    // EX holds the younger producer, so it wins over WB
    always_comb begin
        fwd_sel = REGFILE;
        if (w_ex_hit) begin
            fwd_sel = ALU;
        end else if (w_wb_hit) begin
            fwd_sel = WB;
        end
    end

endmodule
`default_nettype wire

// File: rtl/risc_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : risc_pipe_ctrl
// Description : Pipeline sequencing and hazard controller for the 3-stage
//               RISC core (IF -> ID -> EX/WB). Decides PC / IF_ID advance,
//               ID_EX bubble insertion and operand source, runs an
//               IDLE/RUN/STALL/DRAIN state machine, keeps saturating stall
//               and retire counters and a sticky stall watchdog.
// Build macro : FORWARDING_EN - when defined, EX/WB dependencies are resolved
//               by forwarding instead of stalling (STALL is never entered).
// Ports       : clock, rst (sync, active-high)
//               run                      - 1 execute, 0 drain to idle
//               id_valid/id_rs1/id_rs2   - IF_ID contents (rs1=B, rs2=A)
//               ex_valid/ex_rd           - ID_EX contents
//               wb_valid/wb_rd           - EX_WB contents
//               pc_en/ifid_en/idex_bubble- pipeline register controls
//               fwd_a/fwd_b              - operand source selects
//               state                    - controller state
//               stall_cnt/retire_cnt     - saturating statistics
//               wd_err                   - sticky watchdog error
// Revision    : 1.0 - initial release
// ============================================================================
module risc_pipe_ctrl #(
    parameter int REG_AW     = risc_pkg::REG_AW,
    parameter int CNT_W      = 16,
    parameter int STALL_MAX  = 4,
    parameter int R0_IS_ZERO = 0
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              run,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              ex_valid,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_rd,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              idex_bubble,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  retire_cnt,
    output logic              wd_err
);
    import risc_pkg::*;

    localparam int CONSEC_W = $clog2(STALL_MAX + 1) + 1;

    state_e              r_state;
    state_e              w_next;
    logic [CONSEC_W-1:0] r_consec;
    logic [CNT_W-1:0]    r_stall_cnt;
    logic [CNT_W-1:0]    r_retire_cnt;
    logic                r_wd_err;
    logic                w_wd_trip;
    logic                w_hazard;
    logic                w_live;
    logic [1:0]          w_sel_a;
    logic [1:0]          w_sel_b;

    // Operand A comes from the rs2 field, operand B from rs1
    risc_hazard_cmp #(.REG_AW(REG_AW), .R0_IS_ZERO(R0_IS_ZERO)) u_cmp_a (
        .id_rs    (id_rs2),
        .ex_valid (ex_valid),
        .ex_rd    (ex_rd),
        .wb_valid (wb_valid),
        .wb_rd    (wb_rd),
        .fwd_sel  (w_sel_a)
    );

    risc_hazard_cmp #(.REG_AW(REG_AW), .R0_IS_ZERO(R0_IS_ZERO)) u_cmp_b (
        .id_rs    (id_rs1),
        .ex_valid (ex_valid),
        .ex_rd    (ex_rd),
        .wb_valid (wb_valid),
        .wb_rd    (wb_rd),
        .fwd_sel  (w_sel_b)
    );

    assign w_live = !rst && ((r_state == RUN) || (r_state == STALL));

`ifdef FORWARDING_EN
    logic w_unused_idv;
    assign w_unused_idv = id_valid;
    assign w_hazard     = 1'b0;
    assign fwd_a        = w_live ? w_sel_a : REGFILE;
    assign fwd_b        = w_live ? w_sel_b : REGFILE;
`else
    // Regfile is written at the end of WB, so a WB producer still blocks ID
    assign w_hazard = id_valid && ((w_sel_a != REGFILE) || (w_sel_b != REGFILE));
    assign fwd_a    = REGFILE;
    assign fwd_b    = REGFILE;
`endif

    // Next state and pipeline controls
    always_comb begin
        w_next      = r_state;
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_bubble = 1'b1;
        w_wd_trip   = 1'b0;
        case (r_state)
            IDLE: begin
                if (run) begin
                    w_next = RUN;
                end
            end
            RUN, STALL: begin
                if (!run) begin
                    w_next = DRAIN;
                end else if (w_hazard) begin
                    w_next = STALL;
                    // r_consec counts earlier stall cycles of this streak; one
                    // more STALL would push the streak past STALL_MAX
                    if ((r_state == STALL) &&
                        (r_consec >= CONSEC_W'(STALL_MAX - 1))) begin
                        w_next    = RUN;
                        w_wd_trip = 1'b1;
                    end
                end else begin
                    w_next      = RUN;
                    pc_en       = 1'b1;
                    ifid_en     = 1'b1;
                    idex_bubble = 1'b0;
                end
            end
            DRAIN: begin
                if (!ex_valid && !wb_valid) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
        // Reset aborts at once: the pipeline is frozen in the reset cycle too
        if (rst) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            r_state      <= IDLE;
            r_consec     <= '0;
            r_stall_cnt  <= '0;
            r_retire_cnt <= '0;
            r_wd_err     <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_consec <= (r_state == STALL) ? (r_consec + CONSEC_W'(1)) : '0;
            if ((r_state == STALL) && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (wb_valid && (r_retire_cnt != '1)) begin
                r_retire_cnt <= r_retire_cnt + CNT_W'(1);
            end
            if (w_wd_trip) begin
                r_wd_err <= 1'b1;
            end
        end
    end

    assign state      = r_state;
    assign stall_cnt  = r_stall_cnt;
    assign retire_cnt = r_retire_cnt;
    assign wd_err     = r_wd_err;

endmodule
`default_nettype wire

// File: tb/tb_risc_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_risc_pipe_ctrl
// Description : Scoreboard bench for risc_pipe_ctrl. Each issued cycle pushes
//               the expected outputs from a behavioural model; a negedge
//               monitor pops and compares. Honours FORWARDING_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_risc_pipe_ctrl;

    localparam int REG_AW     = 5;
    localparam int CNT_W      = 4;
    localparam int STALL_MAX  = 4;
    localparam int R0_IS_ZERO = 0;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic              clock = 1'b0;
    logic              rst;
    logic              run;
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              ex_valid;
    logic [REG_AW-1:0] ex_rd;
    logic              wb_valid;
    logic [REG_AW-1:0] wb_rd;
    logic              pc_en;
    logic              ifid_en;
    logic              idex_bubble;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic [1:0]        state;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  retire_cnt;
    logic              wd_err;

    always #5 clock = ~clock;

    risc_pipe_ctrl #(
        .REG_AW     (REG_AW),
        .CNT_W      (CNT_W),
        .STALL_MAX  (STALL_MAX),
        .R0_IS_ZERO (R0_IS_ZERO)
    ) dut (
        .clock       (clock),
        .rst         (rst),
        .run         (run),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .ex_valid    (ex_valid),
        .ex_rd       (ex_rd),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .pc_en       (pc_en),
        .ifid_en     (ifid_en),
        .idex_bubble (idex_bubble),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b),
        .state       (state),
        .stall_cnt   (stall_cnt),
        .retire_cnt  (retire_cnt),
        .wd_err      (wd_err)
    );

    typedef struct {
        int pc_en;
        int ifid_en;
        int bubble;
        int fa;
        int fb;
        int st;
        int sc;
        int rc;
        int wd;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Behavioural model: mode 0 idle, 1 run, 2 stall, 3 drain
    int m_mode   = 0;
    int m_streak = 0;
    int m_stall  = 0;
    int m_ret    = 0;
    int m_wd     = 0;

    function automatic bit hits(logic v, logic [REG_AW-1:0] rd, logic [REG_AW-1:0] rs);
        return v && (rd == rs) && !((R0_IS_ZERO != 0) && (rd == 0));
    endfunction

    task automatic issue();
        exp_t e;
        bit   e1, e2, w1, w2, hz, live, go;
        int   src_a, src_b;
        e1   = hits(ex_valid, ex_rd, id_rs1);
        w1   = hits(wb_valid, wb_rd, id_rs1);
        e2   = hits(ex_valid, ex_rd, id_rs2);
        w2   = hits(wb_valid, wb_rd, id_rs2);
        live = !rst && (m_mode == 1 || m_mode == 2);
`ifdef FORWARDING_EN
        hz    = 1'b0;
        src_b = e1 ? 1 : (w1 ? 2 : 0);
        src_a = e2 ? 1 : (w2 ? 2 : 0);
        if (!live) begin
            src_a = 0;
            src_b = 0;
        end
`else
        hz    = id_valid && (e1 || e2 || w1 || w2);
        src_a = 0;
        src_b = 0;
`endif
        go       = live && run && !hz;
        e.pc_en  = go;
        e.ifid_en = go;
        e.bubble = !go;
        e.fa     = src_a;
        e.fb     = src_b;
        e.st     = m_mode;
        e.sc     = m_stall;
        e.rc     = m_ret;
        e.wd     = m_wd;
        sb_q.push_back(e);

        if (rst) begin
            m_mode = 0; m_streak = 0; m_stall = 0; m_ret = 0; m_wd = 0;
        end else begin
            if (m_mode == 2 && m_stall < CNT_MAX) m_stall++;
            if (wb_valid && m_ret < CNT_MAX) m_ret++;
            // stall cycles in the current streak, including this one
            m_streak = (m_mode == 2) ? m_streak + 1 : 0;
            case (m_mode)
                0: if (run) m_mode = 1;
                1, 2: begin
                    if (!run) m_mode = 3;
                    else if (hz) begin
                        if (m_streak + 1 > STALL_MAX) begin
                            m_wd   = 1;
                            m_mode = 1;
                        end else begin
                            m_mode = 2;
                        end
                    end else m_mode = 1;
                end
                default: if (!ex_valid && !wb_valid) m_mode = 0;
            endcase
        end
    endtask

    task automatic drive(bit r, bit rn, bit idv, int rs1, int rs2,
                         bit exv, int exrd, bit wbv, int wbrd);
        rst      = r;
        run      = rn;
        id_valid = idv;
        id_rs1   = REG_AW'(rs1);
        id_rs2   = REG_AW'(rs2);
        ex_valid = exv;
        ex_rd    = REG_AW'(exrd);
        wb_valid = wbv;
        wb_rd    = REG_AW'(wbrd);
        issue();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(string nm, logic [31:0] act, int exp_v);
        n_tests++;
        if (act !== 32'(exp_v)) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp_v);
        end
    endtask

    always @(negedge clock) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("pc_en",       32'(pc_en),       e.pc_en);
            chk("ifid_en",     32'(ifid_en),     e.ifid_en);
            chk("idex_bubble", 32'(idex_bubble), e.bubble);
            chk("fwd_a",       32'(fwd_a),       e.fa);
            chk("fwd_b",       32'(fwd_b),       e.fb);
            chk("state",       32'(state),       e.st);
            chk("stall_cnt",   32'(stall_cnt),   e.sc);
            chk("retire_cnt",  32'(retire_cnt),  e.rc);
            chk("wd_err",      32'(wd_err),      e.wd);
        end
    end

    initial begin
        rst = 1'b1; run = 1'b0; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0;
        ex_valid = 1'b0; ex_rd = '0; wb_valid = 1'b0; wb_rd = '0;
        // First edge brings the DUT out of X; checking starts afterwards
        @(posedge clock);
        #1;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
        // Start: IDLE then RUN
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
        // EX producer then same producer in WB: two stall cycles
        drive(0, 1, 1, 3, 9, 1, 3, 0, 0);
        drive(0, 1, 1, 3, 9, 0, 0, 1, 3);
        drive(0, 1, 1, 3, 9, 0, 0, 0, 0);
        // WB-only producer on rs2: one stall cycle
        drive(0, 1, 1, 8, 5, 0, 0, 1, 5);
        drive(0, 1, 1, 8, 5, 0, 0, 0, 0);
        // Both producers match rs1, rs2 independent
        drive(0, 1, 1, 3, 7, 1, 3, 1, 3);
        drive(0, 1, 1, 3, 7, 0, 0, 1, 3);
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
        // Drain with work in flight; run=1 while draining is ignored
        drive(0, 0, 0, 0, 0, 1, 20, 0, 0);
        drive(0, 1, 0, 0, 0, 1, 20, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0, 1, 20);
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
        // Persistent hazard: watchdog
        for (int i = 0; i < 12; i++) drive(0, 1, 1, 4, 11, 1, 4, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
        // Mid-run reset clears the sticky error
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
        // Randomized traffic with small register range to provoke matches
        for (int i = 0; i < 500; i++) begin
            drive($urandom_range(0, 149) == 0,
                  $urandom_range(0, 15) != 0,
                  $urandom_range(0, 3) != 0,
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  $urandom_range(0, 1) == 1, int'($urandom_range(0, 3)),
                  $urandom_range(0, 1) == 1, int'($urandom_range(0, 3)));
        end
        rst = 1'b0; run = 1'b0; id_valid = 1'b0; ex_valid = 1'b0; wb_valid = 1'b0;
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clock);
        #1;
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
